evrf_sched_rep: RTL and testbench
=================================

# evrf_sched_rep

Parametrised external-VRF (eVRF) scheduler. It accepts eVRF macro instructions, buffers them, and expands each MOV into a stream of per-vector micro-operations. Generalises the fixed 3-batch eVRF expander with four additions: a parameterised batch count, a programmable address stride, a repeat (loop) count, and a last-uop marker. It sits between the top-level instruction dispatcher and the eVRF datapath, in place of the fixed-batch scheduler.

## Interface
- `VRFAW`, 9: VRF address width.
- `NBATCH`, 3: maximum batches per MOV; also the number of base-address fields.
- `BATCHW`, `$clog2(NBATCH+1)`: width of the batch field.
- `NTAGW`, 5: tag width.
- `SIZEW`, 9: vector-count field width.
- `REPW`, 4: repeat field width.
- `QDEPTH`, 32: depth of the input and output FIFOs (power of 2).
- `MIW`, `2+BATCHW+NTAGW+SIZEW+REPW+VRFAW*(NBATCH+1)`: macro-instruction width. Fields, LSB first:
  - op[1]: 1 = MOV, 0 = NOP.
  - src[1]: 0 = MVU, 1 = VRF.
  - batch[BATCHW]
  - tag[NTAGW]
  - size[SIZEW]
  - repeat[REPW]
  - stride[VRFAW]
  - base0 … base(NBATCH-1), each [VRFAW].
- `UIW`, `VRFAW+2+NTAGW+1`: micro-instruction width. Fields, LSB first:
  - vrf_addr[VRFAW]
  - src_sel[2]: 0 = MVU, 1 = VRF, 2 = FLUSH.
  - tag[NTAGW]
  - last[1]

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: reset, asynchronous and active-high.
- `i_evrf_minst_wr_en`, in, 1: macro-instruction push.
- `o_evrf_minst_wr_rdy`, out, 1: input FIFO not full.
- `i_evrf_minst_wr_din`, in, MIW: macro instruction.
- `i_evrf_uinst_rd_en`, in, 1: micro-instruction pop.
- `o_evrf_uinst_rd_rdy`, out, 1: output FIFO not empty.
- `o_evrf_uinst_rd_dout`, out, UIW: head of the output FIFO (show-ahead).
- `o_busy`, out, 1: FSM is in ISSUE.

## Operation
- Both FIFOs are show-ahead.
  - A push is visible on the read side the next cycle.
  - A push while full is ignored.
  - A pop while empty is ignored.
- FSM states:
  - IDLE: reset state.
  - ISSUE: expanding the head macro instruction.
- Leaving IDLE, when the input FIFO is non-empty:
  - All-ones word, op = NOP, size = 0, or (src = VRF and batch = 0): pop the instruction and stay in IDLE. No uops are emitted.
  - Otherwise: load counters (b = 0, i = 0, r = 0, off = 0) and go to ISSUE. The instruction is not popped yet.
- Derived values:
  - eb = min(batch, NBATCH).
  - nb = NBATCH when src = MVU; nb = eb when src = VRF.
  - npass = max(repeat, 1).
- Each ISSUE cycle with the output FIFO not full writes one uop:
  - vrf_addr = base[b] + off, truncated to VRFAW (wraps).
  - src_sel = {1'b0, src} when b < eb; otherwise 2 (FLUSH).
  - tag = tag field of the instruction.
  - last = 1 only on the final uop of the instruction.
- Counter advance order (innermost first):
  - b increments. At nb-1, b returns to 0, i increments, and off += stride (mod 2^VRFAW).
  - When i reaches size-1 and wraps: i = 0, off = 0, r increments.
  - Final uop is at r = npass-1, i = size-1, b = nb-1. On it: pop the input FIFO and return to IDLE.
- Output FIFO full in ISSUE: no write, counters hold, no uop is lost or duplicated.
- Total uops per MOV = npass × size × nb.

## Timing
- Reset (asynchronous):
  - State goes to IDLE.
  - Counters clear.
  - Both FIFOs empty.
  - `o_evrf_minst_wr_rdy` = 1.
  - `o_evrf_uinst_rd_rdy` = 0.
  - `o_busy` = 0.
  - `o_evrf_uinst_rd_dout` = 0.
- Reset asserted mid-ISSUE discards the in-flight instruction and all queued uops.
- Latency, with the macro instruction pushed at cycle t into empty FIFOs:
  - ISSUE is entered at t+2.
  - The first uop is written at t+2 and visible at t+3.
- Throughput: 1 uop/cycle while the output FIFO is not full.
  - Back-to-back MOVs have one IDLE bubble between them.
- Simultaneous push and pop on either FIFO, including when full or empty, is legal and behaves as a pop followed by a push.
- Macro instructions may be pushed while ISSUE is active. They queue behind the current instruction.

## Test plan
- Reset with traffic present: pulse `rst` asynchronously mid-ISSUE -> `o_busy` = 0 and `o_evrf_uinst_rd_rdy` = 0 immediately; `o_evrf_minst_wr_rdy` = 1.
- MVU MOV with batch = 2, size = 2, stride = 1, repeat = 0, bases 10/20/30 -> exactly these 6 uops:
  - (10,MVU), (20,MVU), (30,FLUSH)
  - (11,MVU), (21,MVU), (31,FLUSH), with last = 1 on this final uop only.
  - First uop visible 3 cycles after the push.
- VRF MOV with batch = 1, size = 3, stride = 4, repeat = 2, base0 = 508 (VRFAW = 9) -> addresses 508, 0, 4, 508, 0, 4; src = VRF throughout; last only on the 6th uop.
- NOP, all-ones word, and size = 0 MOV pushed, then a valid MOV (batch = 3, size = 1) -> only that MOV's 3 uops are produced; the dropped words yield no output.
- Output backpressure: hold `i_evrf_uinst_rd_en` = 0 until the output FIFO holds QDEPTH entries, then drain randomly -> stall and hold with no loss or duplication; total count = npass × size × nb; order matches the golden model.
- Input full: push QDEPTH+1 MOVs with the scheduler stalled -> `o_evrf_minst_wr_rdy` = 0 after QDEPTH pushes; the extra push is ignored; all QDEPTH instructions expand in order.

Source files
------------

// File: rtl/evrf_sched_rep.sv
// eVRF scheduler: buffers eVRF macro instructions and expands each MOV into per-vector
// micro-ops with a parameterised batch count, address stride, repeat count and last marker.

module evrf_sched_rep_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] din,
    input  logic         rd_en,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] dout
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = rd_en && !empty;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    assign do_push = wr_en && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage holds data only and is left out of reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

module evrf_sched_rep #(
    parameter int VRFAW  = 9,
    parameter int NBATCH = 3,
    parameter int BATCHW = $clog2(NBATCH+1),
    parameter int NTAGW  = 5,
    parameter int SIZEW  = 9,
    parameter int REPW   = 4,
    parameter int QDEPTH = 32,
    parameter int MIW    = 2+BATCHW+NTAGW+SIZEW+REPW+VRFAW*(NBATCH+1),
    parameter int UIW    = VRFAW+2+NTAGW+1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_evrf_minst_wr_en,
    output logic           o_evrf_minst_wr_rdy,
    input  logic [MIW-1:0] i_evrf_minst_wr_din,
    input  logic           i_evrf_uinst_rd_en,
    output logic           o_evrf_uinst_rd_rdy,
    output logic [UIW-1:0] o_evrf_uinst_rd_dout,
    output logic           o_busy
);
    localparam int BATCH_LSB  = 2;
    localparam int TAG_LSB    = BATCH_LSB + BATCHW;
    localparam int SIZE_LSB   = TAG_LSB + NTAGW;
    localparam int REP_LSB    = SIZE_LSB + SIZEW;
    localparam int STRIDE_LSB = REP_LSB + REPW;
    localparam int BASE_LSB   = STRIDE_LSB + VRFAW;
    localparam logic [BATCHW-1:0] NBATCH_B = NBATCH[BATCHW-1:0];

    typedef enum logic {IDLE, ISSUE} state_t;

    // eb = min(batch, NBATCH): batches beyond the base-address table are clamped.
    function automatic logic [BATCHW-1:0] sat_batch(input logic [BATCHW-1:0] batch);
        return (batch > NBATCH_B) ? NBATCH_B : batch;
    endfunction

    // npass = max(repeat, 1): a zero repeat still runs the instruction once.
    function automatic logic [REPW-1:0] sat_pass(input logic [REPW-1:0] rep);
        return (rep == '0) ? REPW'(1) : rep;
    endfunction

    state_t            state;
    state_t            state_nx;
    logic [BATCHW-1:0] b;
    logic [BATCHW-1:0] b_nx;
    logic [SIZEW-1:0]  i;
    logic [SIZEW-1:0]  i_nx;
    logic [REPW-1:0]   r;
    logic [REPW-1:0]   r_nx;
    logic [VRFAW-1:0]  off;
    logic [VRFAW-1:0]  off_nx;

    logic              in_full;
    logic              in_empty;
    logic              in_pop;
    logic [MIW-1:0]    mi;
    logic              out_full;
    logic              out_empty;
    logic              out_push;
    logic [UIW-1:0]    uop;

    evrf_sched_rep_fifo #(.W(MIW), .DEPTH(QDEPTH)) u_in_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr_en (i_evrf_minst_wr_en),
        .din   (i_evrf_minst_wr_din),
        .rd_en (in_pop),
        .full  (in_full),
        .empty (in_empty),
        .dout  (mi)
    );

    evrf_sched_rep_fifo #(.W(UIW), .DEPTH(QDEPTH)) u_out_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr_en (out_push),
        .din   (uop),
        .rd_en (i_evrf_uinst_rd_en),
        .full  (out_full),
        .empty (out_empty),
        .dout  (o_evrf_uinst_rd_dout)
    );

    assign o_evrf_minst_wr_rdy = !in_full;
    assign o_evrf_uinst_rd_rdy = !out_empty;
    assign o_busy              = (state == ISSUE);

    logic              mi_op;
    logic              mi_src;
    logic [BATCHW-1:0] mi_batch;
    logic [NTAGW-1:0]  mi_tag;
    logic [SIZEW-1:0]  mi_size;
    logic [REPW-1:0]   mi_rep;
    logic [VRFAW-1:0]  mi_stride;
    logic [VRFAW-1:0]  base_arr [NBATCH];

    assign mi_op     = mi[0];
    assign mi_src    = mi[1];
    assign mi_batch  = mi[BATCH_LSB +: BATCHW];
    assign mi_tag    = mi[TAG_LSB +: NTAGW];
    assign mi_size   = mi[SIZE_LSB +: SIZEW];
    assign mi_rep    = mi[REP_LSB +: REPW];
    assign mi_stride = mi[STRIDE_LSB +: VRFAW];

    for (genvar k = 0; k < NBATCH; k++) begin : g_base
        assign base_arr[k] = mi[BASE_LSB + k*VRFAW +: VRFAW];
    end

    logic [BATCHW-1:0] eb;
    logic [BATCHW-1:0] nb;
    logic [REPW-1:0]   npass;
    logic              drop;
    logic              last_uop;
    logic [VRFAW-1:0]  base_sel;
    logic [VRFAW-1:0]  vrf_addr;
    logic [1:0]        src_sel;

    assign eb    = sat_batch(mi_batch);
    assign nb    = mi_src ? eb : NBATCH_B;
    assign npass = sat_pass(mi_rep);
    // Words that would produce no uops are discarded straight from IDLE.
    assign drop  = (&mi) || !mi_op || (mi_size == '0) || (mi_src && (mi_batch == '0));

    assign last_uop = (r == npass - 1'b1) && (i == mi_size - 1'b1) && (b == nb - 1'b1);

    always_comb begin
        base_sel = base_arr[0];
        for (int k = 1; k < NBATCH; k++) begin
            if (b == BATCHW'(k)) base_sel = base_arr[k];
        end
    end

    assign vrf_addr = base_sel + off;
    assign src_sel  = (b < eb) ? {1'b0, mi_src} : 2'd2;
    assign uop      = {last_uop, mi_tag, src_sel, vrf_addr};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            b     <= '0;
            i     <= '0;
            r     <= '0;
            off   <= '0;
        end else begin
            state <= state_nx;
            b     <= b_nx;
            i     <= i_nx;
            r     <= r_nx;
            off   <= off_nx;
        end
    end

    always_comb begin
        state_nx = state;
        b_nx     = b;
        i_nx     = i;
        r_nx     = r;
        off_nx   = off;
        in_pop   = 1'b0;
        out_push = 1'b0;
        case (state)
            IDLE: begin
                if (!in_empty) begin
                    if (drop) begin
                        in_pop = 1'b1;
                    end else begin
                        b_nx     = '0;
                        i_nx     = '0;
                        r_nx     = '0;
                        off_nx   = '0;
                        state_nx = ISSUE;
                    end
                end
            end
            ISSUE: begin
                // Output full: nothing is written and the counters hold.
                if (!out_full) begin
                    out_push = 1'b1;
                    if (last_uop) begin
                        in_pop   = 1'b1;
                        state_nx = IDLE;
                    end else if (b == nb - 1'b1) begin
                        b_nx = '0;
                        if (i == mi_size - 1'b1) begin
                            i_nx   = '0;
                            off_nx = '0;
                            r_nx   = r + 1'b1;
                        end else begin
                            i_nx   = i + 1'b1;
                            off_nx = off + mi_stride;
                        end
                    end else begin
                        b_nx = b + 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_evrf_sched_rep.sv
// Self-checking bench for evrf_sched_rep: directed cases plus random MOVs checked
// against a loop-based expansion model of the macro instructions.
module tb_evrf_sched_rep;
    localparam int VRFAW  = 9;
    localparam int NBATCH = 3;
    localparam int QDEPTH = 32;
    localparam int MIW    = 58;
    localparam int UIW    = 17;

    logic           clk = 1'b0;
    logic           rst;
    logic           wr_en;
    logic           wr_rdy;
    logic [MIW-1:0] din;
    logic           rd_en;
    logic           rd_rdy;
    logic [UIW-1:0] dout;
    logic           busy;

    int checks = 0;
    int errors = 0;
    logic [UIW-1:0] exp_q [$];

    evrf_sched_rep dut (
        .clk                  (clk),
        .rst                  (rst),
        .i_evrf_minst_wr_en   (wr_en),
        .o_evrf_minst_wr_rdy  (wr_rdy),
        .i_evrf_minst_wr_din  (din),
        .i_evrf_uinst_rd_en   (rd_en),
        .o_evrf_uinst_rd_rdy  (rd_rdy),
        .o_evrf_uinst_rd_dout (dout),
        .o_busy               (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [MIW-1:0] mk_mov(input int op, input int src, input int batch,
        input int tag, input int size, input int rep, input int stride,
        input int b0, input int b1, input int b2);
        logic [MIW-1:0] m;
        m = '0;
        m[0]       = op[0];
        m[1]       = src[0];
        m[2 +: 2]  = batch[1:0];
        m[4 +: 5]  = tag[4:0];
        m[9 +: 9]  = size[8:0];
        m[18 +: 4] = rep[3:0];
        m[22 +: 9] = stride[8:0];
        m[31 +: 9] = b0[8:0];
        m[40 +: 9] = b1[8:0];
        m[49 +: 9] = b2[8:0];
        return m;
    endfunction

    function automatic logic [UIW-1:0] mk_uop(input int addr, input int sel, input int tag, input int last);
        return {last[0], tag[4:0], sel[1:0], addr[8:0]};
    endfunction

    function automatic logic [MIW-1:0] rand_mov(input int max_size);
        int src = $urandom_range(0, 1);
        int batch = src ? $urandom_range(1, 3) : $urandom_range(0, 3);
        return mk_mov(1, src, batch, $urandom_range(0, 31), $urandom_range(1, max_size),
                      $urandom_range(0, 2), $urandom_range(0, 511), $urandom_range(0, 511),
                      $urandom_range(0, 511), $urandom_range(0, 511));
    endfunction

    // Reference: nested loops over pass, vector and batch slot.
    task automatic model_expand(input logic [MIW-1:0] mi);
        logic [MIW-1:0] ones;
        int op, src, batch, tag, size, rep, stride, eb, nb, npass, total, n, addr, sel;
        int base [NBATCH];
        ones   = '1;
        op     = mi[0];
        src    = mi[1];
        batch  = mi[2 +: 2];
        tag    = mi[4 +: 5];
        size   = mi[9 +: 9];
        rep    = mi[18 +: 4];
        stride = mi[22 +: 9];
        for (int k = 0; k < NBATCH; k++) base[k] = mi[31 + 9*k +: 9];
        if (mi == ones || op == 0 || size == 0 || (src == 1 && batch == 0)) return;
        eb    = (batch > NBATCH) ? NBATCH : batch;
        nb    = src ? eb : NBATCH;
        npass = (rep == 0) ? 1 : rep;
        total = npass * size * nb;
        n     = 0;
        for (int p = 0; p < npass; p++)
            for (int v = 0; v < size; v++)
                for (int k = 0; k < nb; k++) begin
                    addr = (base[k] + v * stride) % (1 << VRFAW);
                    sel  = (k < eb) ? src : 2;
                    n++;
                    exp_q.push_back(mk_uop(addr, sel, tag, (n == total) ? 1 : 0));
                end
    endtask

    task automatic push(input logic [MIW-1:0] mi);
        din   = mi;
        wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic drain(input int max_cycles, input int pct);
        int cyc = 0;
        logic [UIW-1:0] e;
        while (exp_q.size() > 0 && cyc < max_cycles) begin
            if (rd_rdy && $urandom_range(0, 99) < pct) begin
                e = exp_q.pop_front();
                chk("uop", 32'(dout), 32'(e));
                rd_en = 1'b1;
            end else begin
                rd_en = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        rd_en = 1'b0;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL drain_timeout observed=%0d uops missing expected=0", exp_q.size());
            exp_q.delete();
        end
        repeat (5) @(negedge clk);
        chk("no_extra_uop", 32'(rd_rdy), 32'd0);
        chk("idle_after", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [MIW-1:0] mi;
        logic [MIW-1:0] ones;
        int a2 [6] = '{10, 20, 30, 11, 21, 31};
        int s2 [6] = '{0, 0, 2, 0, 0, 2};
        int a3 [6] = '{508, 0, 4, 508, 0, 4};
        int w;
        ones  = '1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        din   = '0;
        rst   = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_wr_rdy", 32'(wr_rdy), 32'd1);
        chk("rst_rd_rdy", 32'(rd_rdy), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // MVU MOV: latency and exact uop list
        push(mk_mov(1, 0, 2, 5, 2, 0, 1, 10, 20, 30));
        chk("lat_t1_rd_rdy", 32'(rd_rdy), 32'd0);
        @(negedge clk);
        chk("lat_t2_busy", 32'(busy), 32'd1);
        chk("lat_t2_rd_rdy", 32'(rd_rdy), 32'd0);
        @(negedge clk);
        chk("lat_t3_rd_rdy", 32'(rd_rdy), 32'd1);
        for (int k = 0; k < 6; k++) exp_q.push_back(mk_uop(a2[k], s2[k], 5, (k == 5) ? 1 : 0));
        drain(100, 100);

        // VRF MOV with address wrap and repeat
        push(mk_mov(1, 1, 1, 9, 3, 2, 4, 508, $urandom_range(0, 511), $urandom_range(0, 511)));
        for (int k = 0; k < 6; k++) exp_q.push_back(mk_uop(a3[k], 1, 9, (k == 5) ? 1 : 0));
        drain(100, 100);

        // Dropped words followed by a valid MOV
        mi = mk_mov(0, 0, 3, 3, 4, 1, 2, 1, 2, 3);
        push(mi); model_expand(mi);
        push(ones); model_expand(ones);
        mi = mk_mov(1, 0, 3, 4, 0, 1, 2, 1, 2, 3);
        push(mi); model_expand(mi);
        mi = mk_mov(1, 0, 3, 7, 1, 0, 5, 100, 200, 300);
        push(mi); model_expand(mi);
        drain(200, 100);

        // Asynchronous reset mid-ISSUE
        push(mk_mov(1, 0, 3, 1, 100, 0, 1, 0, 1, 2));
        w = 0;
        while (!busy && w < 10) begin @(negedge clk); w++; end
        repeat (4) @(negedge clk);
        chk("busy_before_rst", 32'(busy), 32'd1);
        chk("rd_rdy_before_rst", 32'(rd_rdy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_rd_rdy", 32'(rd_rdy), 32'd0);
        chk("arst_wr_rdy", 32'(wr_rdy), 32'd1);
        chk("arst_dout", 32'(dout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("post_rst_rd_rdy", 32'(rd_rdy), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);

        // Output backpressure, then random drain
        mi = mk_mov(1, 0, $urandom_range(0, 3), 12, 20, 1, $urandom_range(0, 511),
                    $urandom_range(0, 511), $urandom_range(0, 511), $urandom_range(0, 511));
        push(mi); model_expand(mi);
        repeat (50) @(negedge clk);
        chk("bp_busy_stalled", 32'(busy), 32'd1);
        chk("bp_rd_rdy", 32'(rd_rdy), 32'd1);
        drain(2000, 50);

        // Input FIFO full: first MOV stalls on a full output FIFO
        for (int k = 0; k <= QDEPTH; k++) begin
            chk("in_wr_rdy", 32'(wr_rdy), (k < QDEPTH) ? 32'd1 : 32'd0);
            mi = (k == 0) ? mk_mov(1, 0, 3, 2, 20, 1, 3, 7, 8, 9) : rand_mov(4);
            if (k < QDEPTH) model_expand(mi);
            push(mi);
        end
        chk("in_full_wr_rdy", 32'(wr_rdy), 32'd0);
        drain(8000, 60);

        // Random mix including NOPs
        for (int k = 0; k < 8; k++) begin
            mi = rand_mov(6);
            if ($urandom_range(0, 3) == 0) mi[0] = 1'b0;
            push(mi); model_expand(mi);
        end
        drain(4000, 70);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
